// File: rtl/ifu_fetch_if.sv
// Instruction-memory fetch bus: a single outstanding request held until acknowledged.
interface ifu_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  // Fetch unit side: drives the request and address, receives the instruction word.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  // Instruction memory side.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over a
// req/ack bus, holds it for decode and computes the next PC on retire.
// A misaligned redirect target freezes the unit in S_ERR until reset.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  ifu_fetch_if.master      imem,
  output logic [31:0]      instr_o,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  input  logic             wbeq_i,
  input  logic             wja_i,
  input  logic             wjr_i,
  input  logic [31:0]      jr_target_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  output logic [CNT_W-1:0] retired_cnt_o,
  output logic             fetch_err_o
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_VALID = 2'd1,
    S_ERR   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               req_q, req_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [31:0]        pc_plus4;
  logic [31:0]        branch_off;
  logic [31:0]        next_pc;

  assign pc_plus4   = pc_q + 32'd4;
  assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Redirect target selection; only consumed on the retire cycle.
  always_comb begin
    if (wjr_i) begin
      next_pc = jr_target_i;
    end else if (wja_i) begin
      next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    end else if (wbeq_i) begin
      next_pc = pc_plus4 + branch_off;
    end else begin
      next_pc = pc_plus4;
    end
  end

  // Next-state and register updates for the fetch/hold/error sequence.
  always_comb begin
    // NOTE: every _d gets its current value first so no path through the
    // case can leave a variable unassigned and infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    case (state_q)
      S_REQ: begin
        // The ack only counts once the registered request is visible on the bus.
        if (req_q && imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = S_VALID;
        end else begin
          req_d   = 1'b1;
        end
      end

      S_VALID: begin
        if (instr_ready_i) begin
          valid_d = 1'b0;
          if (next_pc[1:0] != 2'b00) begin
            err_d   = 1'b1;
            req_d   = 1'b0;
            state_d = S_ERR;
          end else begin
            pc_d    = next_pc;
            cnt_d   = cnt_q + CNT_W'(1);
            req_d   = 1'b1;
            state_d = S_REQ;
          end
        end
      end

      S_ERR: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
      end

      default: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        state_d = S_REQ;
      end
    endcase
  end

  // State and datapath registers; reset aborts any in-flight handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr_o        = instr_q;
  assign instr_valid_o  = valid_q;
  assign pc_o           = pc_q;
  assign pc_plus4_o     = pc_plus4;
  assign retired_cnt_o  = cnt_q;
  assign fetch_err_o    = err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios plus randomized fetch/retire traffic
// checked against a PC/counter model computed from the redirect rules.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          CNT_W    = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      instr;
  logic             instr_valid;
  logic             instr_ready;
  logic             wbeq, wja, wjr;
  logic [31:0]      jr_target;
  logic [31:0]      pc, pc_plus4;
  logic [CNT_W-1:0] retired_cnt;
  logic             fetch_err;

  int total = 0;
  int bad   = 0;

  logic [31:0]      m_pc;
  logic [CNT_W-1:0] m_cnt;

  always #5 clk = ~clk;

  ifu_fetch_if imem_bus ();

  ifu_fetch #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (imem_bus),
    .instr_o       (instr),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .wbeq_i        (wbeq),
    .wja_i         (wja),
    .wjr_i         (wjr),
    .jr_target_i   (jr_target),
    .pc_o          (pc),
    .pc_plus4_o    (pc_plus4),
    .retired_cnt_o (retired_cnt),
    .fetch_err_o   (fetch_err)
  );

  // Reference next-PC from the redirect rules, in plain signed arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] cur_instr,
                                             input logic b, input logic a, input logic j,
                                             input logic [31:0] t);
    logic [31:0] link;
    int          off;
    link = cur_pc + 32'd4;
    off  = int'($signed(cur_instr[15:0])) * 4;
    if (j) return t;
    if (a) return {link[31:28], cur_instr[25:0], 2'b00};
    if (b) return link + 32'(off);
    return link;
  endfunction

  task automatic idle_inputs();
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = $urandom();
    instr_ready = 1'b0;
    wbeq = 1'b0; wja = 1'b0; wjr = 1'b0;
    jr_target = $urandom();
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_pc  = RESET_PC;
    m_cnt = '0;
  endtask

  // Waits (bounded) at negedges until a request is on the bus.
  task automatic wait_req(output int waited, output bit ok);
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 40; i++) begin
      if (!ok) begin
        if (imem_bus.imem_req === 1'b1) ok = 1'b1;
        else begin
          @(negedge clk);
          waited++;
        end
      end
    end
  endtask

  // Serves one fetch after 'delay' wait cycles; reports address and stability.
  task automatic fetch(input logic [31:0] word, input int delay, output bit ok,
                       output bit stable, output int waited, output logic [31:0] addr);
    wait_req(waited, ok);
    stable = 1'b1;
    addr   = imem_bus.imem_addr;
    if (ok) begin
      repeat (delay) begin
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = $urandom();
        @(negedge clk);
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== addr || instr_valid !== 1'b0)
          stable = 1'b0;
      end
      imem_bus.imem_ack   = 1'b1;
      imem_bus.imem_rdata = word;
      @(negedge clk);
      imem_bus.imem_ack   = 1'b0;
      imem_bus.imem_rdata = $urandom();
    end
  endtask

  // Presents one retire cycle with the given strobes, then scrambles the strobes.
  task automatic retire(input logic b, input logic a, input logic j, input logic [31:0] t);
    instr_ready = 1'b1;
    wbeq = b; wja = a; wjr = j; jr_target = t;
    @(negedge clk);
    instr_ready = 1'b0;
    wbeq = 1'($urandom()); wja = 1'($urandom()); wjr = 1'($urandom());
    jr_target = $urandom();
  endtask

  // Sequential retires of a zero word until the model PC reaches target.
  task automatic advance_to(input logic [31:0] target);
    bit ok, st;
    int w;
    logic [31:0] a;
    for (int i = 0; i < 64; i++) begin
      if (m_pc != target) begin
        fetch(32'h0, 0, ok, st, w, a);
        retire(1'b0, 1'b0, 1'b0, 32'h0);
        m_pc  = m_pc + 32'd4;
        m_cnt = m_cnt + 1'b1;
      end
    end
    total++; if (pc !== target) begin bad++; $display("FAIL advance_pc: got %h want %h", pc, target); end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (imem_bus.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", imem_bus.imem_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h want 0", instr); end
    total++; if (pc !== RESET_PC) begin bad++; $display("FAIL rst_pc: got %h want %h", pc, RESET_PC); end
    total++; if (pc_plus4 !== 32'h0000_3004) begin bad++; $display("FAIL rst_pc4: got %h want 3004", pc_plus4); end
    total++; if (retired_cnt !== '0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", retired_cnt); end
    total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", fetch_err); end
    rst_n = 1'b1;
    m_pc = RESET_PC; m_cnt = '0;
    total++; if (imem_bus.imem_req !== 1'b0) begin bad++; $display("FAIL rel_req_early: got %b want 0", imem_bus.imem_req); end
    @(negedge clk);
    total++; if (imem_bus.imem_req !== 1'b1) begin bad++; $display("FAIL rel_req_first_edge: got %b want 1", imem_bus.imem_req); end
    total++; if (imem_bus.imem_addr !== RESET_PC) begin bad++; $display("FAIL rel_addr: got %h want %h", imem_bus.imem_addr, RESET_PC); end
  endtask

  task automatic test_sequential();
    bit ok, st;
    int w;
    logic [31:0] a;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      fetch(32'h0, 0, ok, st, w, a);
      total++; if (!ok) begin bad++; $display("FAIL seq_req_timeout[%0d]: no request", k); end
      total++; if (a !== RESET_PC + 32'(4 * k)) begin bad++; $display("FAIL seq_addr[%0d]: got %h want %h", k, a, RESET_PC + 32'(4 * k)); end
      if (k > 0) begin
        total++; if (w !== 0) begin bad++; $display("FAIL seq_b2b[%0d]: waited %0d want 0", k, w); end
      end
      total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL seq_valid[%0d]: got %b want 1", k, instr_valid); end
      total++; if (pc_plus4 !== m_pc + 32'd4) begin bad++; $display("FAIL seq_pc4[%0d]: got %h want %h", k, pc_plus4, m_pc + 32'd4); end
      retire(1'b0, 1'b0, 1'b0, 32'h0);
      m_pc = m_pc + 32'd4; m_cnt = m_cnt + 1'b1;
      total++; if (retired_cnt !== m_cnt) begin bad++; $display("FAIL seq_cnt[%0d]: got %0d want %0d", k, retired_cnt, m_cnt); end
    end
  endtask

  task automatic test_ack_delay();
    bit ok, st;
    int w;
    logic [31:0] a;
    do_reset();
    fetch(32'hDEAD_BEEC, 3, ok, st, w, a);
    total++; if (!st) begin bad++; $display("FAIL delay_stable: req/addr moved or valid early"); end
    total++; if (a !== RESET_PC) begin bad++; $display("FAIL delay_addr: got %h want %h", a, RESET_PC); end
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL delay_valid: got %b want 1", instr_valid); end
    total++; if (instr !== 32'hDEAD_BEEC) begin bad++; $display("FAIL delay_instr: got %h want DEADBEEC", instr); end
    total++; if (imem_bus.imem_req !== 1'b0) begin bad++; $display("FAIL delay_req_drop: got %b want 0", imem_bus.imem_req); end
    // Ack while no request is outstanding must not disturb the held word.
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    total++; if (instr !== 32'hDEAD_BEEC) begin bad++; $display("FAIL stray_ack_instr: got %h want DEADBEEC", instr); end
  endtask

  task automatic test_branch();
    bit ok, st;
    int w;
    logic [31:0] a;
    do_reset();
    advance_to(32'h0000_3010);
    fetch(32'h1000_FFFC, 0, ok, st, w, a);
    retire(1'b1, 1'b0, 1'b0, 32'h0);
    total++; if (imem_bus.imem_addr !== 32'h0000_3004) begin bad++; $display("FAIL beq_taken: got %h want 00003004", imem_bus.imem_addr); end
    m_pc = 32'h0000_3004; m_cnt = m_cnt + 1'b1;
    advance_to(32'h0000_3010);
    fetch(32'h1000_FFFC, 0, ok, st, w, a);
    retire(1'b0, 1'b0, 1'b0, 32'h0);
    total++; if (imem_bus.imem_addr !== 32'h0000_3014) begin bad++; $display("FAIL beq_not_taken: got %h want 00003014", imem_bus.imem_addr); end
  endtask

  task automatic test_jump();
    bit ok, st;
    int w;
    logic [31:0] a;
    do_reset();
    advance_to(32'h0000_3020);
    fetch(32'h0C00_0C10, 0, ok, st, w, a);
    retire(1'b0, 1'b1, 1'b0, 32'h0);
    total++; if (imem_bus.imem_addr !== 32'h0000_3040) begin bad++; $display("FAIL jal_target: got %h want 00003040", imem_bus.imem_addr); end
    do_reset();
    advance_to(32'h0000_3020);
    fetch(32'h0C00_0C10, 0, ok, st, w, a);
    retire(1'b1, 1'b1, 1'b1, 32'h0000_3100);
    total++; if (imem_bus.imem_addr !== 32'h0000_3100) begin bad++; $display("FAIL jr_priority: got %h want 00003100", imem_bus.imem_addr); end
  endtask

  task automatic test_wrap();
    bit ok, st;
    int w;
    logic [31:0] a;
    do_reset();
    fetch(32'h0, 0, ok, st, w, a);
    retire(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    fetch(32'h0, 0, ok, st, w, a);
    total++; if (a !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr: got %h want FFFFFFFC", a); end
    total++; if (pc_plus4 !== 32'h0) begin bad++; $display("FAIL wrap_pc4: got %h want 00000000", pc_plus4); end
    retire(1'b0, 1'b0, 1'b0, 32'h0);
    total++; if (imem_bus.imem_addr !== 32'h0 || fetch_err !== 1'b0) begin
      bad++; $display("FAIL wrap_next: got addr %h err %b want 00000000 0", imem_bus.imem_addr, fetch_err);
    end
  endtask

  task automatic test_error();
    bit ok, st;
    int w;
    logic [31:0] a;
    do_reset();
    advance_to(32'h0000_3020);
    fetch(32'h0, 0, ok, st, w, a);
    retire(1'b0, 1'b0, 1'b1, 32'h0000_3102);
    total++; if (fetch_err !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", fetch_err); end
    total++; if (pc !== 32'h0000_3020) begin bad++; $display("FAIL err_pc: got %h want 00003020", pc); end
    for (int i = 0; i < 5; i++) begin
      imem_bus.imem_ack = 1'b1; instr_ready = 1'b1;
      @(negedge clk);
      total++; if (imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b1 || pc !== 32'h0000_3020) begin
        bad++; $display("FAIL err_hold[%0d]: got req %b valid %b err %b pc %h want 0 0 1 00003020",
                        i, imem_bus.imem_req, instr_valid, fetch_err, pc);
      end
    end
    do_reset();
    total++; if (pc !== RESET_PC || fetch_err !== 1'b0) begin
      bad++; $display("FAIL err_clear: got pc %h err %b want %h 0", pc, fetch_err, RESET_PC);
    end
  endtask

  task automatic test_reset_mid_handshake();
    bit ok, st;
    int w;
    logic [31:0] a;
    do_reset();
    advance_to(32'h0000_3008);
    wait_req(w, ok);
    total++; if (imem_bus.imem_addr !== 32'h0000_3008) begin bad++; $display("FAIL mid_addr: got %h want 00003008", imem_bus.imem_addr); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (imem_bus.imem_req !== 1'b0) begin bad++; $display("FAIL mid_req_async: got %b want 0", imem_bus.imem_req); end
    total++; if (pc !== RESET_PC) begin bad++; $display("FAIL mid_pc_async: got %h want %h", pc, RESET_PC); end
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hBAD0_0000;
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = RESET_PC; m_cnt = '0;
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    total++; if (instr_valid !== 1'b0 || imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== RESET_PC) begin
      bad++; $display("FAIL mid_late_ack: got valid %b req %b addr %h want 0 1 %h",
                      instr_valid, imem_bus.imem_req, imem_bus.imem_addr, RESET_PC);
    end
    fetch(32'h0000_0040, 0, ok, st, w, a);
    total++; if (instr !== 32'h0000_0040) begin bad++; $display("FAIL mid_refetch: got %h want 00000040", instr); end
    retire(1'b0, 1'b0, 1'b0, 32'h0);
    total++; if (retired_cnt !== CNT_W'(1)) begin bad++; $display("FAIL mid_cnt: got %0d want 1", retired_cnt); end
  endtask

  task automatic test_random();
    bit ok, st;
    int w, dly, rdy;
    logic [31:0] a, word, t, nxt;
    logic b, ja, j;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      word = $urandom();
      dly  = $urandom_range(0, 3);
      fetch(word, dly, ok, st, w, a);
      total++; if (!ok) begin bad++; $display("FAIL rnd_req_timeout[%0d]", n); end
      total++; if (a !== m_pc) begin bad++; $display("FAIL rnd_addr[%0d]: got %h want %h", n, a, m_pc); end
      total++; if (!st) begin bad++; $display("FAIL rnd_stable[%0d]", n); end
      rdy = $urandom_range(0, 2);
      repeat (rdy) begin
        wbeq = 1'($urandom()); wja = 1'($urandom()); wjr = 1'($urandom());
        @(negedge clk);
      end
      total++; if (instr_valid !== 1'b1 || instr !== word) begin
        bad++; $display("FAIL rnd_instr[%0d]: got valid %b instr %h want 1 %h", n, instr_valid, instr, word);
      end
      total++; if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4) begin
        bad++; $display("FAIL rnd_pc[%0d]: got %h/%h want %h/%h", n, pc, pc_plus4, m_pc, m_pc + 32'd4);
      end
      b  = 1'($urandom());
      ja = ($urandom_range(0, 3) == 0);
      j  = ($urandom_range(0, 3) == 0);
      t  = $urandom() & 32'hFFFF_FFFC;
      nxt = model_next(m_pc, word, b, ja, j, t);
      retire(b, ja, j, t);
      m_pc  = nxt;
      m_cnt = m_cnt + 1'b1;
      total++; if (retired_cnt !== m_cnt || fetch_err !== 1'b0) begin
        bad++; $display("FAIL rnd_cnt[%0d]: got %0d err %b want %0d 0", n, retired_cnt, fetch_err, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_ack_delay();
    test_branch();
    test_jump();
    test_wrap();
    test_error();
    test_reset_mid_handshake();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit sitting directly upstream of the single-cycle control unit decode stage.
- Owns the PC register and issues fetch requests to instruction memory over a req/ack handshake.
- Holds the fetched word for decode, then computes the next PC from the decode redirect strobes (wbeq, wja, wjr) when the core retires the instruction.
- Provides pc and pc+4 (jal link value) to the datapath.

Parameters:
RESET_PC, 32'h0000_3000, PC loaded on reset and first address fetched
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch address (= pc while imem_req=1)
imem_ack  in  1  memory has imem_rdata valid this cycle (sampled only while imem_req=1)
imem_rdata  in  32  instruction word from memory
instr  out  32  held instruction word for decode
instr_valid  out  1  instr is valid and stable
instr_ready  in  1  core retires current instr this cycle
wbeq  in  1  taken-branch strobe from decode (already qualified by zero)
wja  in  1  jump-and-link strobe from decode
wjr  in  1  jump-register strobe from decode
jr_target  in  32  rs register value for jr
pc  out  32  address of instr
pc_plus4  out  32  pc+4, jal link value
retired_cnt  out  CNT_W  number of retired instructions
fetch_err  out  1  sticky misaligned-target error

Behaviour:
- Reset (rst_n=0, asynchronous): state=S_REQ, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, retired_cnt=0, fetch_err=0.
- imem_req is registered. It rises in the first clock edge after rst_n deasserts.
- States: S_REQ, S_VALID, S_ERR.
- S_REQ:
  - imem_req=1 and imem_addr=pc.
  - On imem_ack=1: instr<=imem_rdata, instr_valid<=1, imem_req<=0, go to S_VALID.
  - Otherwise stay; request and address are held stable until ack.
- S_VALID:
  - instr_valid=1 and imem_req=0. instr and pc are held stable until instr_ready=1.
  - On instr_ready=1: pc<=next_pc, retired_cnt<=retired_cnt+1 (wraps at 2^CNT_W), instr_valid<=0, imem_req<=1, go to S_REQ.
  - If next_pc[1:0]!=0: fetch_err<=1, go to S_ERR; pc is not updated.
- S_ERR: imem_req=0, instr_valid=0. Remains in S_ERR until reset.
- next_pc is combinational and evaluated only in S_VALID with instr_ready=1. Priority: wjr > wja > wbeq > sequential.
  - wjr: jr_target
  - wja: {pc_plus4[31:28], instr[25:0], 2'b00}
  - wbeq: pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}
  - none: pc_plus4
- Simultaneous strobes (illegal from decode) resolve by priority; no error is raised.
- Strobes are ignored outside the retire cycle.
- pc_plus4 = pc+4 modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000 without error.
- Branch and jump arithmetic is modulo 2^32.
- Throughput: with zero-wait memory and instr_ready held high, one instruction retires every 2 cycles.
- First imem_ack can be accepted at the earliest in the cycle imem_req first reads 1.
- imem_ack while imem_req=0 is ignored.
- Reset asserted mid-handshake aborts it: imem_req drops asynchronously and no partial state survives.

Test Plan:
- Reset release, zero-wait memory returning 32'h0000_0000, instr_ready=1 -> imem_addr sequence 3000, 3004, 3008; retired_cnt increments every 2 cycles; pc_plus4=3004 while pc=3000.
- imem_ack delayed 3 cycles -> imem_req and imem_addr held stable 3 cycles; instr_valid rises the cycle after ack.
- At pc=3010 with instr=32'h1000_FFFC and wbeq=1 on retire -> next fetch addr 3004. Same with wbeq=0 -> 3014.
- At pc=3020 with instr=32'h0C00_0C10 and wja=1 -> next addr 0000_3040. Same cycle with wjr=1, jr_target=0000_3100 -> 3100 (wjr wins).
- wjr=1 with jr_target=0000_3102 -> fetch_err=1, pc stays 3020, imem_req stays 0 indefinitely. Then rst_n pulse -> pc=3000, fetch_err=0.
- rst_n asserted while imem_req=1 awaiting ack -> imem_req=0 immediately (no clock edge). Late ack is ignored; fetch restarts at 3000.
